inval_coalesce_fifo: RTL and testbench
======================================

# inval_coalesce_fifo

Buffers cache-line invalidation requests between the vector unit's AXI invalidation filter and the scalar core's accelerator-response invalidation inputs (`inval_addr`/`inval_valid`/`inval_ready`). Write addresses are aligned to L1 data-cache lines. An address is dropped if its line is already pending in the queue. The queue decouples the filter from core back-pressure, so bursts of vector stores do not stall the AXI write path.

## Interface
Parameters:
- `AddrWidth`, 64: invalidation address width.
- `L1LineWidth`, 16: L1 D-cache line size in bytes. Power of two, at least 2.
- `Depth`, 4: queue entries. Power of two, at least 2.
- `CntWidth`, 16: width of the coalesce statistics counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `en_i`  in  1  coherence enable (`acc_cons_en`).
- `inval_addr_i`  in  AddrWidth  invalidation address from the filter.
- `inval_valid_i`  in  1  request valid.
- `inval_ready_o`  out  1  request accepted.
- `inval_addr_o`  out  AddrWidth  line-aligned address to the core.
- `inval_valid_o`  out  1  queue head valid.
- `inval_ready_i`  in  1  core accepts the head.
- `usage_o`  out  $clog2(Depth+1)  number of valid entries.
- `coalesce_cnt_o`  out  CntWidth  saturating count of dropped duplicates.

## Operation
Definitions:
- `OFF` = $clog2(L1LineWidth).
- `line(a)` = `a` with bits [OFF-1:0] forced to 0.
- Storage: `Depth` address registers, each with a valid bit.
- Pointers: `wr_ptr` and `rd_ptr`, $clog2(Depth) bits each, wrapping modulo Depth.
- `count` holds 0..Depth.

Handshakes:
- Push: `inval_valid_i && inval_ready_o`.
- Pop: `inval_valid_o && inval_ready_i`.

Ready rule:
- `inval_ready_o` = `!en_i || count != Depth`.
- It does not depend on `inval_ready_i` or on the input address.

Hit (coalesce) check:
- `hit` = `line(inval_addr_i)` matches any valid entry.
- The entry being popped in the same cycle is excluded from the match.

Push behaviour:
- `en_i`=0: accept and discard, no enqueue, counter unchanged. Entries already queued still drain normally.
- `en_i`=1, `hit`=1: accept, no enqueue. `coalesce_cnt_o` increments and saturates at all-ones.
- `en_i`=1, `hit`=0: write `line(inval_addr_i)` at `wr_ptr`, set its valid bit, advance `wr_ptr`.

Pop behaviour:
- Clear the valid bit at `rd_ptr` and advance `rd_ptr`.

Count update:
- `count` += enqueue − pop.
- A simultaneous enqueue and pop leaves `count` unchanged.
- Enqueue when full is impossible, because ready is low.

Outputs:
- `inval_valid_o` = `count != 0`.
- `inval_addr_o` = entry[`rd_ptr`]. The value is don't-care while `inval_valid_o`=0.
- `usage_o` = `count`.

Ordering: strict FIFO. Entries are never reordered or merged after enqueue.

Reset (asynchronous, active-low):
- Pointers, `count`, all valid bits and `coalesce_cnt_o` go to 0.
- Address storage may be left unreset.
- Reset asserted mid-operation discards all pending entries immediately.

## Timing
- Output reset values: `inval_valid_o`=0, `inval_addr_o`=0, `inval_ready_o`=1, `usage_o`=0, `coalesce_cnt_o`=0.
- Latency: an entry pushed on edge N appears on `inval_*_o` after edge N. There is no combinational fall-through from input to output.
- Throughput: 1 push and 1 pop per cycle, sustained.
- Full with a pop in the same cycle: `inval_ready_o` stays 0 that cycle. A push is accepted the next cycle. This avoids a ready-to-ready combinational path.
- Empty with a push in the same cycle: no pop is possible that cycle. `inval_valid_o`=1 next cycle.
- Handshake rules:
  - `inval_valid_o` and `inval_addr_o` are stable until popped.
  - `inval_valid_o` never drops without a pop, except on reset.
  - Upstream may hold `inval_valid_i` while ready=0. It must keep `inval_addr_i` stable while doing so.
- `en_i` toggling takes effect in the same cycle via `inval_ready_o` and the push behaviour. It has no effect on entries already queued.
- Pointer wrap: `Depth` pushes from reset return `wr_ptr` to 0, and entry 0 is reused after it pops.

## Test plan
- Basic: `en_i`=1, `L1LineWidth`=16. Push 0x1004 with `inval_ready_i`=1. Required: `inval_valid_o`=1 with `inval_addr_o`=0x1000 on the next cycle, popped that cycle, `usage_o` back to 0.
- Coalesce: `inval_ready_i`=0. Push 0x2000, 0x200C, 0x3000. Required: `usage_o`=2, `coalesce_cnt_o`=1, outputs 0x2000 then 0x3000 once ready rises.
- Full/back-pressure: `Depth`=4, `inval_ready_i`=0. Push 5 distinct lines. Required: `inval_ready_o`=0 after the 4th push, and the 5th is held. Raise ready for 1 cycle. Required: `inval_ready_o`=1 the following cycle, the 5th is accepted, order is preserved.
- Pop-exclusion: queue holds only 0x4000 and it is being popped while 0x4008 is pushed in the same cycle. Required: 0x4000 is re-enqueued, `usage_o`=1 next cycle, `coalesce_cnt_o` unchanged.
- Disable and reset: `en_i`=0, push 0x5000. Required: accepted, `usage_o`=0, no output. Then with 3 entries queued, assert `rst_ni`=0 for 1 cycle. Required: `inval_valid_o`=0 and `usage_o`=0 immediately, with `inval_ready_o`=1.
- Streaming wrap: 20 distinct line addresses back-to-back with `inval_ready_i`=1. Required: 20 outputs in order, one per cycle after the first cycle of latency, `usage_o` ≤ 1 throughout.

Source files
------------

// File: rtl/inval_coalesce_fifo.sv
// Purpose: line-aligned invalidation queue that drops addresses whose line is already pending.
// Latency: one cycle from an accepted push to inval_valid_o; no combinational input-to-output path.
// Backpressure: inval_ready_o drops only when enabled and full; a same-cycle pop does not reopen it.
module inval_coalesce_fifo #(
  parameter int AddrWidth   = 64,
  parameter int L1LineWidth = 16,
  parameter int Depth       = 4,
  parameter int CntWidth    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [AddrWidth-1:0]         inval_addr_i,
  input  logic                         inval_valid_i,
  output logic                         inval_ready_o,
  output logic [AddrWidth-1:0]         inval_addr_o,
  output logic                         inval_valid_o,
  input  logic                         inval_ready_i,
  output logic [$clog2(Depth+1)-1:0]   usage_o,
  output logic [CntWidth-1:0]          coalesce_cnt_o
);

  localparam int Off  = $clog2(L1LineWidth);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth+1);
  localparam logic [AddrWidth-1:0] LineMask = {{(AddrWidth-Off){1'b1}}, {Off{1'b0}}};
  localparam logic [CntW-1:0]      FullCnt  = CntW'(Depth);

  logic [AddrWidth-1:0] mem_q [Depth];
  logic [Depth-1:0]     vld_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [CntWidth-1:0]  coal_q;

  logic [AddrWidth-1:0] in_line;
  logic                 push;
  logic                 pop;
  logic                 hit;
  logic                 enq;
  logic                 coal;

  // Ready never looks at the consumer side, so a full queue stays closed for the cycle it pops.
  assign inval_ready_o  = !en_i || (count_q != FullCnt);
  assign inval_valid_o  = (count_q != '0);
  assign inval_addr_o   = mem_q[rd_ptr_q];
  assign usage_o        = count_q;
  assign coalesce_cnt_o = coal_q;

  assign in_line = inval_addr_i & LineMask;
  assign push    = inval_valid_i && inval_ready_o;
  assign pop     = inval_valid_o && inval_ready_i;
  assign enq     = push && en_i && !hit;
  assign coal    = push && en_i && hit;

  // Line match against pending entries, ignoring the head if it leaves this cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (vld_q[i] && (mem_q[i] == in_line) && !(pop && (rd_ptr_q == PtrW'(i)))) begin
        hit = 1'b1;
      end
    end
  end

  // Address storage; cleared on reset so the head output reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq) begin
      mem_q[wr_ptr_q] <= in_line;
    end
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (enq) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (enq && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Saturating count of duplicates dropped while coherence is enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coal_q <= '0;
    end else if (coal && (coal_q != {CntWidth{1'b1}})) begin
      coal_q <= coal_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_inval_coalesce_fifo.sv
// Purpose: self-checking bench for inval_coalesce_fifo (directed table, corner sequences, random run).
// Latency: expectations are the outputs seen in a cycle after that cycle's inputs are applied.
// Backpressure: random consumer ready and random producer valid against a queue-based model.
module tb_inval_coalesce_fifo;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic [AW-1:0] inval_addr_i;
  logic          inval_valid_i;
  logic          inval_ready_o;
  logic [AW-1:0] inval_addr_o;
  logic          inval_valid_o;
  logic          inval_ready_i;
  logic [2:0]    usage_o;
  logic [CW-1:0] coalesce_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] mq[$];
  int            mcnt;

  inval_coalesce_fifo #(
    .AddrWidth(AW), .L1LineWidth(16), .Depth(DEPTH), .CntWidth(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .inval_addr_i(inval_addr_i), .inval_valid_i(inval_valid_i), .inval_ready_o(inval_ready_o),
    .inval_addr_o(inval_addr_o), .inval_valid_o(inval_valid_o), .inval_ready_i(inval_ready_i),
    .usage_o(usage_o), .coalesce_cnt_o(coalesce_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          vld;
    logic          rdy;
    logic          e_ready;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    int            e_usage;
    int            e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare against the model, advance the model and the clock.
  task automatic cyc(input logic en, input logic [AW-1:0] a, input logic v, input logic r);
    logic          exp_rdy;
    logic          exp_vld;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] la;
    bit            found;
    en_i = en; inval_addr_i = a; inval_valid_i = v; inval_ready_i = r;
    #1;
    exp_rdy = !en || (mq.size() != DEPTH);
    exp_vld = (mq.size() != 0);
    chk("m_ready", AW'(inval_ready_o), AW'(exp_rdy));
    chk("m_valid", AW'(inval_valid_o), AW'(exp_vld));
    chk("m_usage", AW'(usage_o), AW'(mq.size()));
    chk("m_cnt", AW'(coalesce_cnt_o), AW'(mcnt));
    if (exp_vld) chk("m_addr", inval_addr_o, mq[0]);
    do_push = v && exp_rdy;
    do_pop  = exp_vld && r;
    if (do_pop) void'(mq.pop_front());
    if (do_push && en) begin
      la = a & ~64'hF;
      found = 0;
      foreach (mq[i]) if (mq[i] == la) found = 1;
      if (found) begin
        if (mcnt < CMAX) mcnt++;
      end else begin
        mq.push_back(la);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic en, input logic [AW-1:0] a, input logic v, input logic r,
                     input logic er, input logic ev, input logic [AW-1:0] ea,
                     input int eu, input int ec);
    vec_t t;
    t.en = en; t.addr = a; t.vld = v; t.rdy = r;
    t.e_ready = er; t.e_valid = ev; t.e_addr = ea; t.e_usage = eu; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  initial begin
    logic [AW-1:0] base;
    rst_ni = 1'b0; en_i = 1'b1; inval_addr_i = '0; inval_valid_i = 1'b0; inval_ready_i = 1'b0;
    mq.delete(); mcnt = 0;

    //     en  addr     vld rdy   rdy_o vld_o addr_o  usage cnt
    // basic push/pop
    add(1, 64'h1004, 1, 1,   1, 0, 64'h0,    0, 0);
    add(1, 64'h0,    0, 1,   1, 1, 64'h1000, 1, 0);
    add(1, 64'h0,    0, 0,   1, 0, 64'h0,    0, 0);
    // coalesce
    add(1, 64'h2000, 1, 0,   1, 0, 64'h0,    0, 0);
    add(1, 64'h200C, 1, 0,   1, 1, 64'h2000, 1, 0);
    add(1, 64'h3000, 1, 0,   1, 1, 64'h2000, 1, 1);
    add(1, 64'h0,    0, 1,   1, 1, 64'h2000, 2, 1);
    add(1, 64'h0,    0, 1,   1, 1, 64'h3000, 1, 1);
    add(1, 64'h0,    0, 0,   1, 0, 64'h0,    0, 1);
    // pop exclusion
    add(1, 64'h4000, 1, 0,   1, 0, 64'h0,    0, 1);
    add(1, 64'h4008, 1, 1,   1, 1, 64'h4000, 1, 1);
    add(1, 64'h0,    0, 0,   1, 1, 64'h4000, 1, 1);
    add(1, 64'h0,    0, 1,   1, 1, 64'h4000, 1, 1);
    // full / back-pressure
    add(1, 64'hA000, 1, 0,   1, 0, 64'h0,    0, 1);
    add(1, 64'hB000, 1, 0,   1, 1, 64'hA000, 1, 1);
    add(1, 64'hC000, 1, 0,   1, 1, 64'hA000, 2, 1);
    add(1, 64'hD000, 1, 0,   1, 1, 64'hA000, 3, 1);
    add(1, 64'hE000, 1, 0,   0, 1, 64'hA000, 4, 1);
    add(1, 64'hE000, 1, 1,   0, 1, 64'hA000, 4, 1);
    add(1, 64'hE000, 1, 0,   1, 1, 64'hB000, 3, 1);
    add(1, 64'h0,    0, 1,   0, 1, 64'hB000, 4, 1);
    add(1, 64'h0,    0, 1,   1, 1, 64'hC000, 3, 1);
    add(1, 64'h0,    0, 1,   1, 1, 64'hD000, 2, 1);
    add(1, 64'h0,    0, 1,   1, 1, 64'hE000, 1, 1);
    // disabled: accepted and discarded
    add(0, 64'h5000, 1, 1,   1, 0, 64'h0,    0, 1);
    add(0, 64'h0,    0, 0,   1, 0, 64'h0,    0, 1);
    // three entries pending, then disabling keeps them
    add(1, 64'h6000, 1, 0,   1, 0, 64'h0,    0, 1);
    add(1, 64'h7000, 1, 0,   1, 1, 64'h6000, 1, 1);
    add(1, 64'h8000, 1, 0,   1, 1, 64'h6000, 2, 1);
    add(0, 64'h6000, 0, 0,   1, 1, 64'h6000, 3, 1);

    // reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", AW'(inval_valid_o), AW'(0));
    chk("rst_addr", inval_addr_o, 64'h0);
    chk("rst_ready", AW'(inval_ready_o), AW'(1));
    chk("rst_usage", AW'(usage_o), AW'(0));
    chk("rst_cnt", AW'(coalesce_cnt_o), AW'(0));
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // directed table
    for (int k = 0; k < vecs.size(); k++) begin
      en_i = vecs[k].en; inval_addr_i = vecs[k].addr;
      inval_valid_i = vecs[k].vld; inval_ready_i = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d_ready", k), AW'(inval_ready_o), AW'(vecs[k].e_ready));
      chk($sformatf("v%0d_valid", k), AW'(inval_valid_o), AW'(vecs[k].e_valid));
      chk($sformatf("v%0d_usage", k), AW'(usage_o), AW'(vecs[k].e_usage));
      chk($sformatf("v%0d_cnt", k), AW'(coalesce_cnt_o), AW'(vecs[k].e_cnt));
      if (vecs[k].e_valid) chk($sformatf("v%0d_addr", k), inval_addr_o, vecs[k].e_addr);
      cyc(vecs[k].en, vecs[k].addr, vecs[k].vld, vecs[k].rdy);
    end

    // asynchronous reset with three entries pending: effect must be immediate
    inval_valid_i = 1'b0; inval_ready_i = 1'b0; en_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", AW'(inval_valid_o), AW'(0));
    chk("arst_usage", AW'(usage_o), AW'(0));
    chk("arst_ready", AW'(inval_ready_o), AW'(1));
    chk("arst_cnt", AW'(coalesce_cnt_o), AW'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mq.delete(); mcnt = 0;
    cyc(1, 64'h0, 0, 0);

    // streaming: 20 distinct lines back-to-back, consumer always ready
    base = 64'h10_0000;
    for (int k = 0; k <= 20; k++) begin
      en_i = 1'b1; inval_ready_i = 1'b1;
      inval_valid_i = (k < 20); inval_addr_i = base + 64'(k * 16) + 64'(k % 16);
      #1;
      chk($sformatf("s%0d_usage_le1", k), AW'(usage_o <= 3'd1), AW'(1));
      if (k > 0) begin
        chk($sformatf("s%0d_valid", k), AW'(inval_valid_o), AW'(1));
        chk($sformatf("s%0d_addr", k), inval_addr_o, base + 64'((k - 1) * 16));
      end
      cyc(1'b1, inval_addr_i, inval_valid_i, 1'b1);
    end
    chk("s_drained", AW'(inval_valid_o), AW'(0));

    // randomized run against the model (small line pool so duplicates and saturation occur)
    for (int n = 0; n < 3000; n++) begin
      logic          r_en;
      logic [AW-1:0] r_a;
      r_en = ($urandom_range(0, 7) != 0);
      r_a  = 64'h8000 + 64'($urandom_range(0, 7) * 16) + 64'($urandom_range(0, 15));
      cyc(r_en, r_a, ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
